// File: rtl/game_io_bridge.sv
// Game event bridge: per-channel pending slots, round-robin push into an event FIFO,
// processor-side pop at the proc_en step rate, saturating score and last-status tracking.
module game_io_bridge #(
   parameter int NUM_CH     = 2,
   parameter int PTS_W      = 3,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV        = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         ev_valid,
   input  logic [NUM_CH*PTS_W-1:0]   ev_points,
   input  logic [NUM_CH*2-1:0]       ev_code,
   output logic                      proc_en,
   output logic                      rd_valid,
   output logic [DATA_W-1:0]         rd_data,
   input  logic                      rd_ack,
   input  logic                      clr_overflow,
   output logic [DATA_W-1:0]         score,
   output logic [1:0]                status,
   output logic                      overflow
);

   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SLOT_W = PTS_W + 2;
   localparam int ENT_W  = SLOT_W + CH_W;
   localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
   localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
   localparam logic [AW-1:0]    AW_ONE   = AW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   // With DIV=1 every cycle is a step, including the first one out of reset
   localparam logic             PEN_RST  = (DIV == 1) ? 1'b1 : 1'b0;

   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic              proc_en_q, proc_en_d;
   logic [NUM_CH-1:0] slot_full_q, slot_full_d;
   logic [SLOT_W-1:0] slot_data_q [NUM_CH];
   logic [SLOT_W-1:0] slot_data_d [NUM_CH];
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] score_q, score_d;
   logic [1:0]        status_q, status_d;
   logic              ovf_q, ovf_d;

   logic              grant_any_s, push_s, pop_s, drop_s, fifo_full_s, rd_valid_s;
   logic [CH_W-1:0]   grant_idx_s;
   logic [ENT_W-1:0]  head_s;
   logic [DATA_W:0]   sum_s;
   logic [DATA_W-1:0] rd_data_s;

   // Step-enable divider: pulse while the counter sits at DIV-1
   always_comb begin
      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + DIV_ONE;
      end
      proc_en_d = (div_cnt_d == DIV_LAST);
   end

   // Round-robin search for the first full slot at or after rr_q
   always_comb begin
      int idx_v;
      idx_v       = 0;
      grant_any_s = 1'b0;
      grant_idx_s = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx_v = int'(rr_q) + k;
         idx_v = (idx_v >= NUM_CH) ? (idx_v - NUM_CH) : idx_v;
         if (!grant_any_s && slot_full_q[idx_v]) begin
            grant_any_s = 1'b1;
            grant_idx_s = CH_W'(idx_v);
         end else begin
            grant_any_s = grant_any_s;
         end
      end
      fifo_full_s = (cnt_q == CNT_FULL);
      rd_valid_s  = (cnt_q != '0);
      pop_s       = rd_ack & proc_en_q & rd_valid_s;
      push_s      = grant_any_s & (~fifo_full_s | pop_s);
      if (push_s) begin
         rr_d = (grant_idx_s == CH_LAST) ? '0 : (grant_idx_s + CH_ONE);
      end else begin
         rr_d = rr_q;
      end
   end

   // Slot capture: a slot being granted this cycle may accept a new event
   always_comb begin
      logic granted_v;
      granted_v   = 1'b0;
      drop_s      = 1'b0;
      slot_full_d = slot_full_q;
      slot_data_d = slot_data_q;
      for (int i = 0; i < NUM_CH; i++) begin
         granted_v = push_s && (grant_idx_s == CH_W'(i));
         if (ev_valid[i] && (!slot_full_q[i] || granted_v)) begin
            slot_full_d[i] = 1'b1;
            slot_data_d[i] = {ev_code[i*2 +: 2], ev_points[i*PTS_W +: PTS_W]};
         end else if (ev_valid[i]) begin
            drop_s = 1'b1;
         end else if (granted_v) begin
            slot_full_d[i] = 1'b0;
         end else begin
            slot_full_d[i] = slot_full_q[i];
         end
      end
      ovf_d = drop_s ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
   end

   // FIFO storage, pointers, occupancy, and pop-side score/status update
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      head_s   = mem_q[rd_ptr_q];
      if (push_s) begin
         mem_d[wr_ptr_q] = {grant_idx_s, slot_data_q[grant_idx_s]};
         wr_ptr_d        = wr_ptr_q + AW_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      sum_s = {1'b0, score_q} + (DATA_W + 1)'(head_s[PTS_W-1:0]);
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW_ONE;
         score_d  = sum_s[DATA_W] ? '1 : sum_s[DATA_W-1:0];
         status_d = head_s[PTS_W+1:PTS_W];
      end else begin
         score_d  = score_q;
         status_d = status_q;
      end
      rd_data_s = '0;
      if (rd_valid_s) begin
         rd_data_s[ENT_W-1:0] = head_s;
      end else begin
         rd_data_s = '0;
      end
   end

   // Control and accounting registers
   always_ff @(posedge clock) begin
      if (reset) begin
         div_cnt_q   <= '0;
         proc_en_q   <= PEN_RST;
         slot_full_q <= '0;
         rr_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         score_q     <= '0;
         status_q    <= 2'b00;
         ovf_q       <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         proc_en_q   <= proc_en_d;
         slot_full_q <= slot_full_d;
         rr_q        <= rr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         score_q     <= score_d;
         status_q    <= status_d;
         ovf_q       <= ovf_d;
      end
   end

   // Payload storage; contents are qualified by the slot flags and the occupancy count
   always_ff @(posedge clock) begin
      slot_data_q <= slot_data_d;
      mem_q       <= mem_d;
   end

   assign proc_en  = proc_en_q;
   assign rd_valid = rd_valid_s;
   assign rd_data  = rd_data_s;
   assign score    = score_q;
   assign status   = status_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_game_io_bridge.sv
// Directed bench for game_io_bridge (NUM_CH=2, PTS_W=3, DATA_W=8, FIFO_DEPTH=8, DIV=4).
module tb_game_io_bridge;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] ev_valid;
   logic [5:0] ev_points;
   logic [3:0] ev_code;
   logic       proc_en, rd_valid, rd_ack, clr_overflow, overflow;
   logic [7:0] rd_data, score;
   logic [1:0] status;
   int         checks = 0;
   int         errors = 0;

   game_io_bridge #(
      .NUM_CH(2), .PTS_W(3), .DATA_W(8), .FIFO_DEPTH(8), .DIV(4)
   ) dut (
      .clock(clock), .reset(reset), .ev_valid(ev_valid), .ev_points(ev_points),
      .ev_code(ev_code), .proc_en(proc_en), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_ack(rd_ack), .clr_overflow(clr_overflow), .score(score), .status(status),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a step with data available, check the head, then pop it
   task automatic pop_one(input string tag, input logic [7:0] exp_data);
      int n;
      n = 0;
      while (!(proc_en === 1'b1 && rd_valid === 1'b1) && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, 32'(proc_en & rd_valid), 32'd1);
      chk({tag, "_data"}, 32'(rd_data), 32'(exp_data));
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
   endtask

   // Overflow-test event k: points=(k+1)%8, code=k%4, channel 0
   function automatic logic [7:0] ent(input int k);
      return 8'(((k & 3) << 3) | ((k + 1) & 7));
   endfunction

   initial begin
      reset = 1'b1; ev_valid = 2'b00; ev_points = 6'd0; ev_code = 4'd0;
      rd_ack = 1'b0; clr_overflow = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // Reset state and divider phase
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      for (int c = 0; c < 12; c++) begin
         chk($sformatf("proc_en_c%0d", c), 32'(proc_en), ((c % 4) == 3) ? 32'd1 : 32'd0);
         tick();
      end

      // Cycle 12: both channels strobe together
      ev_valid = 2'b11; ev_points = {3'd3, 3'd5}; ev_code = {2'd2, 2'd1};
      tick();
      ev_valid = 2'b00;
      tick();
      chk("rr_first_valid", 32'(rd_valid), 32'd1);
      chk("rr_first_data", 32'(rd_data), 32'h0D);
      tick();
      chk("rr_pen_c15", 32'(proc_en), 32'd1);
      chk("rr_head_c15", 32'(rd_data), 32'h0D);
      rd_ack = 1'b1;
      tick();
      chk("rr_score1", 32'(score), 32'd5);
      chk("rr_status1", 32'(status), 32'd1);
      chk("rr_second_data", 32'(rd_data), 32'h33);
      tick(); tick();
      chk("ack_no_pen_score", 32'(score), 32'd5);
      chk("ack_no_pen_valid", 32'(rd_valid), 32'd1);
      tick(); tick();
      rd_ack = 1'b0;
      chk("rr_score2", 32'(score), 32'd8);
      chk("rr_status2", 32'(status), 32'd2);
      chk("rr_empty_valid", 32'(rd_valid), 32'd0);
      chk("rr_empty_data", 32'(rd_data), 32'd0);

      // Cycles 20..29: ch0 strobes every cycle with no pops
      for (int k = 0; k < 10; k++) begin
         ev_valid = 2'b01;
         ev_points = {3'd0, 3'((k + 1) & 7)};
         ev_code = {2'd0, 2'(k & 3)};
         if (k == 9) chk("ovf_before_block", 32'(overflow), 32'd0);
         tick();
      end
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_score_hold", 32'(score), 32'd8);
      clr_overflow = 1'b1;
      tick();
      chk("ovf_set_wins", 32'(overflow), 32'd1);
      ev_valid = 2'b00;
      tick();
      clr_overflow = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      chk("full_head", 32'(rd_data), 32'(ent(0)));

      // Full FIFO with pending slot: push and pop together
      pop_one("fullpp", ent(0));
      chk("fullpp_score", 32'(score), 32'd9);
      chk("fullpp_new_head", 32'(rd_data), 32'(ent(1)));
      chk("fullpp_no_ovf", 32'(overflow), 32'd0);
      for (int k = 1; k < 9; k++) pop_one($sformatf("drain%0d", k), ent(k));
      chk("drain_empty", 32'(rd_valid), 32'd0);
      chk("drain_score", 32'(score), 32'd37);
      chk("drain_status", 32'(status), 32'd0);

      // Saturation: 31 pops of 7 points take 37 to 254
      for (int n = 0; n < 31; n++) begin
         ev_valid = 2'b01; ev_points = {3'd0, 3'd7}; ev_code = {2'd0, 2'd3};
         tick();
         ev_valid = 2'b00;
         tick(); tick();
         pop_one("sat_fill", 8'h1F);
      end
      chk("sat_254", 32'(score), 32'd254);
      chk("sat_status", 32'(status), 32'd3);
      for (int n = 0; n < 2; n++) begin
         ev_valid = 2'b01;
         tick();
         ev_valid = 2'b00;
         tick(); tick();
         pop_one("sat_top", 8'h1F);
         chk($sformatf("sat_255_%0d", n), 32'(score), 32'd255);
      end

      // Fresh start, then build 3 entries, score 9 and a drop before a mid-stream reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_score", 32'(score), 32'd0);
      ev_valid = 2'b11; ev_points = {3'd5, 3'd4}; ev_code = 4'd0;
      tick(); tick();
      ev_valid = 2'b00;
      chk("ch1_drop_ovf", 32'(overflow), 32'd1);
      pop_one("ms_pop0", 8'h04);
      pop_one("ms_pop1", 8'h25);
      chk("ms_score9", 32'(score), 32'd9);
      ev_valid = 2'b11;
      tick();
      ev_valid = 2'b00;
      tick(); tick(); tick();
      chk("ms_pre_valid", 32'(rd_valid), 32'd1);
      chk("ms_pre_ovf", 32'(overflow), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("ms_rd_valid", 32'(rd_valid), 32'd0);
      chk("ms_rd_data", 32'(rd_data), 32'd0);
      chk("ms_score", 32'(score), 32'd0);
      chk("ms_overflow", 32'(overflow), 32'd0);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("ms_proc_en_c%0d", c), 32'(proc_en), (c == 3) ? 32'd1 : 32'd0);
         tick();
      end
      chk("ms_still_empty", 32'(rd_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
